// File: rtl/acq_pkg.sv
// Shared types and constants for the trigger/acquisition scheduler.
// State encoding is one-hot; clamp minimums guard against degenerate settings.
package acq_pkg;

  localparam int ACQ_CYCLE_W = 20;
  localparam int ACQ_PULSE_W = 12;
  localparam int ACQ_SIZE_W  = 16;
  localparam int ACQ_RATE_W  = 3;
  localparam int ACQ_OVR_W   = 16;

  localparam int CYC_MIN  = 2;
  localparam int RATE_MIN = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_PULSE   = 3'b010,
    ST_CAPTURE = 3'b100
  } state_e;

endpackage

// File: rtl/trig_edge_sync.sv
// Two-flop synchronizer for the external trigger followed by a selectable edge detector.
// Only instantiated when EXT_TRIG_EN is defined.
module trig_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  input  logic i_falling,
  output logic o_edge
);

  // [0],[1] form the synchronizer, [2] holds the previous synchronized level
  logic [2:0] sync_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], i_async};
    end
  end

  assign o_edge = i_falling ? (~sync_q[1] & sync_q[2]) : (sync_q[1] & ~sync_q[2]);

endmodule

// File: rtl/trig_acq_sched.sv
// Periodic transducer trigger and decimated ADC capture-frame scheduler.
// Define EXT_TRIG_EN to allow trigger points from the synchronized i_ext_trig edge.
module trig_acq_sched
  import acq_pkg::*;
#(
  parameter int CYCLE_W = ACQ_CYCLE_W,
  parameter int PULSE_W = ACQ_PULSE_W,
  parameter int SIZE_W  = ACQ_SIZE_W,
  parameter int RATE_W  = ACQ_RATE_W,
  parameter int OVR_W   = ACQ_OVR_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_run,
  input  logic               i_outmode,
  input  logic               i_outnegedge,
  input  logic [CYCLE_W-1:0] i_cycle,
  input  logic [PULSE_W-1:0] i_pulse,
  input  logic [SIZE_W-1:0]  i_wave_size,
  input  logic [RATE_W-1:0]  i_wave_rate,
  input  logic               i_ext_trig,
  input  logic               i_buf_ready,
  output logic               o_trig,
  output logic               o_sample_en,
  output logic               o_frame_start,
  output logic               o_frame_end,
  output logic               o_frame_abort,
  output logic               o_busy,
  output logic [OVR_W-1:0]   o_skip_cnt
);

  state_e             state_q, state_d;
  logic [CYCLE_W-1:0] per_cnt_q, per_cnt_d;
  logic [CYCLE_W-1:0] per_len_q, per_len_d;
  logic [PULSE_W-1:0] pul_rem_q, pul_rem_d;
  logic [RATE_W-1:0]  rate_q, rate_d;
  logic [RATE_W-1:0]  dec_q, dec_d;
  logic [SIZE_W-1:0]  smp_rem_q, smp_rem_d;
  logic [OVR_W-1:0]   skip_q, skip_d;
  logic               pol_q, pol_d;
  logic               trig_q, trig_d;
  logic               se_q, se_d;
  logic               fs_q, fs_d;
  logic               fe_q, fe_d;
  logic               ab_q, ab_d;

  logic [CYCLE_W-1:0] cyc_c, cyc_m1, pw_wide;
  logic [PULSE_W-1:0] pw_c;
  logic [RATE_W-1:0]  rate_c;
  logic [SIZE_W-1:0]  size_c;
  logic               int_tp, tp;

  // Settings clamped to usable values at the moment they are latched
  assign cyc_c   = (i_cycle < CYCLE_W'(CYC_MIN)) ? CYCLE_W'(CYC_MIN) : i_cycle;
  assign cyc_m1  = cyc_c - CYCLE_W'(1);
  assign pw_wide = (i_pulse == '0) ? CYCLE_W'(1) : CYCLE_W'(i_pulse);
  assign pw_c    = PULSE_W'((pw_wide > cyc_m1) ? cyc_m1 : pw_wide);
  assign rate_c  = (i_wave_rate == '0) ? RATE_W'(RATE_MIN) : i_wave_rate;
  assign size_c  = (i_wave_size == '0) ? SIZE_W'(1) : i_wave_size;

  // Period counter: the length is re-read from i_cycle every time it passes 0
  always_comb begin
    per_cnt_d = per_cnt_q;
    per_len_d = per_len_q;
    int_tp    = 1'b0;
    if (!i_run) begin
      per_cnt_d = '0;
    end else if (per_cnt_q == '0) begin
      int_tp    = 1'b1;
      per_len_d = cyc_c;
      per_cnt_d = CYCLE_W'(1);
    end else if (per_cnt_q == per_len_q - CYCLE_W'(1)) begin
      per_cnt_d = '0;
    end else begin
      per_cnt_d = per_cnt_q + CYCLE_W'(1);
    end
  end

`ifdef EXT_TRIG_EN
  logic ext_edge;

  trig_edge_sync u_edge_sync (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_async   (i_ext_trig),
    .i_falling (i_outnegedge),
    .o_edge    (ext_edge)
  );

  assign tp = i_run & (i_outmode ? ext_edge : int_tp);
`else
  logic unused_ext;
  assign unused_ext = i_ext_trig ^ i_outmode;
  assign tp         = int_tp;
`endif

  always_comb begin
    state_d   = state_q;
    pul_rem_d = pul_rem_q;
    rate_d    = rate_q;
    dec_d     = dec_q;
    smp_rem_d = smp_rem_q;
    skip_d    = skip_q;
    pol_d     = pol_q;
    trig_d    = pol_q;
    se_d      = 1'b0;
    fs_d      = 1'b0;
    fe_d      = 1'b0;
    ab_d      = 1'b0;

    if ((state_q != ST_IDLE) && !i_run) begin
      state_d = ST_IDLE;
      ab_d    = 1'b1;
    end else begin
      if (state_q != ST_IDLE) begin
        if (pul_rem_q != '0) begin
          trig_d    = ~pol_q;
          pul_rem_d = pul_rem_q - PULSE_W'(1);
        end
        // Strobe on a zero decimation count, then reload it with rate-1
        if (smp_rem_q != '0) begin
          if (dec_q == '0) begin
            se_d      = 1'b1;
            fe_d      = (smp_rem_q == SIZE_W'(1));
            smp_rem_d = smp_rem_q - SIZE_W'(1);
            dec_d     = rate_q - RATE_W'(1);
          end else begin
            dec_d = dec_q - RATE_W'(1);
          end
        end
      end

      case (state_q)
        ST_PULSE: begin
          if (pul_rem_q == '0) begin
            state_d = (smp_rem_q == '0) ? ST_IDLE : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (smp_rem_q == '0) begin
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase

      if (tp) begin
        if ((state_q != ST_IDLE) || !i_buf_ready) begin
          if (skip_q != '1) begin
            skip_d = skip_q + OVR_W'(1);
          end
        end else begin
          state_d   = ST_PULSE;
          fs_d      = 1'b1;
          pol_d     = i_outnegedge;
          trig_d    = i_outnegedge;
          pul_rem_d = pw_c;
          rate_d    = rate_c;
          dec_d     = '0;
          smp_rem_d = size_c;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      per_cnt_q <= '0;
      per_len_q <= '0;
      pul_rem_q <= '0;
      rate_q    <= '0;
      dec_q     <= '0;
      smp_rem_q <= '0;
      skip_q    <= '0;
      pol_q     <= 1'b0;
      trig_q    <= 1'b0;
      se_q      <= 1'b0;
      fs_q      <= 1'b0;
      fe_q      <= 1'b0;
      ab_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      per_len_q <= per_len_d;
      pul_rem_q <= pul_rem_d;
      rate_q    <= rate_d;
      dec_q     <= dec_d;
      smp_rem_q <= smp_rem_d;
      skip_q    <= skip_d;
      pol_q     <= pol_d;
      trig_q    <= trig_d;
      se_q      <= se_d;
      fs_q      <= fs_d;
      fe_q      <= fe_d;
      ab_q      <= ab_d;
    end
  end

  assign o_trig        = trig_q;
  assign o_sample_en   = se_q;
  assign o_frame_start = fs_q;
  assign o_frame_end   = fe_q;
  assign o_frame_abort = ab_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_skip_cnt    = skip_q;

endmodule

// File: tb/tb_trig_acq_sched.sv
// Self-checking bench for trig_acq_sched: frame-level reference model plus directed literal checks.
// Build with EXT_TRIG_EN defined to add the external-trigger scenario.
module tb_trig_acq_sched;

  localparam int CYCLE_W = 20;
  localparam int PULSE_W = 12;
  localparam int SIZE_W  = 16;
  localparam int RATE_W  = 3;
  localparam int OVR_W   = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               run, outmode, outneg, ext_trig, buf_ready;
  logic [CYCLE_W-1:0] cycle;
  logic [PULSE_W-1:0] pulse;
  logic [SIZE_W-1:0]  size;
  logic [RATE_W-1:0]  rate;
  logic               o_trig, o_sample_en, o_frame_start, o_frame_end, o_frame_abort, o_busy;
  logic [OVR_W-1:0]   o_skip_cnt;

  trig_acq_sched dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_run         (run),
    .i_outmode     (outmode),
    .i_outnegedge  (outneg),
    .i_cycle       (cycle),
    .i_pulse       (pulse),
    .i_wave_size   (size),
    .i_wave_rate   (rate),
    .i_ext_trig    (ext_trig),
    .i_buf_ready   (buf_ready),
    .o_trig        (o_trig),
    .o_sample_en   (o_sample_en),
    .o_frame_start (o_frame_start),
    .o_frame_end   (o_frame_end),
    .o_frame_abort (o_frame_abort),
    .o_busy        (o_busy),
    .o_skip_cnt    (o_skip_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int c = 0;

  // Frame-level reference model
  bit m_prev_run;
  int m_last_tp, m_per;
  bit m_fv, m_pol;
  int m_F, m_pw, m_rate, m_size, m_S, m_abort_at, m_skip;
`ifdef EXT_TRIG_EN
  bit [2:0] m_ext;
`endif

  // Observed-output tallies for the directed scenarios
  int dc_fs, dc_hi, dc_lo, dc_se, dc_fe, dc_ab, last_fs;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, c, act, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_run = 1'b0;
    m_last_tp  = 0;
    m_per      = 2;
    m_fv       = 1'b0;
    m_pol      = 1'b0;
    m_F = 0; m_pw = 1; m_rate = 1; m_size = 1; m_S = 0;
    m_abort_at = -1;
    m_skip     = 0;
`ifdef EXT_TRIG_EN
    m_ext = '0;
`endif
  endtask

  task automatic clear_tallies();
    dc_fs = 0; dc_hi = 0; dc_lo = 0; dc_se = 0; dc_fe = 0; dc_ab = 0; last_fs = -1;
  endtask

  // Check outputs of cycle c, advance the model with this cycle's inputs, step one clock
  task automatic tick();
    bit e_busy, e_fs, e_trig, e_se, e_fe, e_ab, itp, tp;
    int k, per_c, pw, e_last;
    e_busy = m_fv && (c >= m_F) && (c < m_S);
    e_fs   = m_fv && (c == m_F);
    e_trig = (e_busy && (c >= m_F + 1) && (c <= m_F + m_pw)) ? !m_pol : m_pol;
    k      = c - m_F - 1;
    e_se   = e_busy && (k >= 0) && ((k % m_rate) == 0) && ((k / m_rate) < m_size);
    e_fe   = e_se && ((k / m_rate) == m_size - 1);
    e_ab   = (c == m_abort_at);

    chk("trig", o_trig, e_trig);
    chk("sample_en", o_sample_en, e_se);
    chk("frame_start", o_frame_start, e_fs);
    chk("frame_end", o_frame_end, e_fe);
    chk("frame_abort", o_frame_abort, e_ab);
    chk("busy", o_busy, e_busy);
    chk("skip_cnt", o_skip_cnt, m_skip);

    if (o_frame_start) begin dc_fs++; last_fs = c; end
    if (o_trig) dc_hi++; else dc_lo++;
    if (o_sample_en) dc_se++;
    if (o_frame_end) begin dc_fe++; $display("frame complete at cycle %0d", c); end
    if (o_frame_abort) begin dc_ab++; $display("frame aborted at cycle %0d", c); end

    if (e_busy && !run) begin
      m_S        = c + 1;
      m_abort_at = c + 1;
    end
    per_c = (cycle < 2) ? 2 : int'(cycle);
    itp   = run && (!m_prev_run || (c == m_last_tp + m_per));
    if (itp) begin
      m_last_tp = c;
      m_per     = per_c;
    end
    tp = itp;
`ifdef EXT_TRIG_EN
    if (outmode)
      tp = run && (outneg ? (!m_ext[1] && m_ext[2]) : (m_ext[1] && !m_ext[2]));
    m_ext = {m_ext[1:0], ext_trig};
`endif
    if (tp) begin
      if (e_busy || !buf_ready) begin
        if (m_skip < 65535) m_skip++;
      end else begin
        pw = (pulse == 0) ? 1 : int'(pulse);
        if (pw > per_c - 1) pw = per_c - 1;
        m_fv   = 1'b1;
        m_F    = c + 1;
        m_pw   = pw;
        m_rate = (rate == 0) ? 1 : int'(rate);
        m_size = (size == 0) ? 1 : int'(size);
        m_pol  = outneg;
        e_last = m_F + 1 + (m_size - 1) * m_rate;
        m_S    = ((e_last > m_F + m_pw) ? e_last : m_F + m_pw) + 1;
      end
    end
    m_prev_run = run;

    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_cfg(input int cy, input int pu, input int sz, input int rt, input bit neg);
    cycle  = CYCLE_W'(cy);
    pulse  = PULSE_W'(pu);
    size   = SIZE_W'(sz);
    rate   = RATE_W'(rt);
    outneg = neg;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; run = 1'b0; outmode = 1'b0; ext_trig = 1'b0; buf_ready = 1'b1;
    set_cfg(100, 10, 8, 1, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("reset_trig", o_trig, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_skip", o_skip_cnt, 0);
    chk("reset_frame_start", o_frame_start, 0);
    chk("reset_sample_en", o_sample_en, 0);
    ticks(3);

    // 1: 100-clock period, 10-clock pulse, 8 back-to-back samples
    clear_tallies();
    run = 1'b1;
    ticks(300);
    chk("t1_frames", dc_fs, 3);
    chk("t1_trig_high", dc_hi, 30);
    chk("t1_samples", dc_se, 24);
    chk("t1_frame_ends", dc_fe, 3);
    run = 1'b0;
    ticks(3);

    // 2: inverted polarity, trigger idles high
    set_cfg(50, 5, 4, 1, 1'b1);
    run = 1'b1;
    tick();
    clear_tallies();
    ticks(99);
    chk("t2_frames", dc_fs, 2);
    chk("t2_trig_low", dc_lo, 10);
    run = 1'b0;
    ticks(3);

    // 3: capture longer than the period, every other trigger skipped
    set_cfg(20, 5, 30, 1, 1'b0);
    clear_tallies();
    run = 1'b1;
    ticks(200);
    chk("t3_frames", dc_fs, 5);
    chk("t3_skips", o_skip_cnt, 5);
    run = 1'b0;
    ticks(3);

    // 4: buffer not ready across three trigger points
    set_cfg(30, 3, 4, 1, 1'b0);
    buf_ready = 1'b0;
    clear_tallies();
    run = 1'b1;
    ticks(61);
    chk("t4_no_frames", dc_fs, 0);
    chk("t4_skips", o_skip_cnt, 8);
    buf_ready = 1'b1;
    ticks(40);
    chk("t4_frames", dc_fs, 1);
    chk("t4_start_cycle", last_fs - (c - 101), 91);
    run = 1'b0;
    ticks(3);

    // 5: run dropped while the 4th of 16 samples is out
    set_cfg(100, 10, 16, 2, 1'b0);
    clear_tallies();
    run = 1'b1;
    ticks(8);
    run = 1'b0;
    ticks(4);
    chk("t5_samples", dc_se, 4);
    chk("t5_aborts", dc_ab, 1);
    chk("t5_no_frame_end", dc_fe, 0);
    chk("t5_trig_after", o_trig, 0);
    clear_tallies();
    run = 1'b1;
    ticks(40);
    chk("t5_restart", dc_fs, 1);
    chk("t5_restart_ends", dc_fe, 1);
    run = 1'b0;
    ticks(2);

    // Asynchronous reset in the middle of a frame
    set_cfg(50, 10, 16, 1, 1'b1);
    run = 1'b1;
    ticks(6);
    rst = 1'b1;
    #2;
    chk("arst_busy", o_busy, 0);
    chk("arst_trig", o_trig, 0);
    chk("arst_skip", o_skip_cnt, 0);
    chk("arst_sample_en", o_sample_en, 0);
    @(posedge clk);
    #1;
    chk("arst_no_abort", o_frame_abort, 0);
    run = 1'b0;
    rst = 1'b0;
    model_reset();
    ticks(2);

    // Randomized settings, run drops and buffer stalls against the model
    for (int i = 0; i < 4000; i++) begin
      if (run) begin
        if ($urandom_range(0, 149) == 0) run = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        run = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) buf_ready = !buf_ready;
      if ($urandom_range(0, 99) == 0) cycle = CYCLE_W'($urandom_range(0, 40));
      if ($urandom_range(0, 59) == 0) pulse = PULSE_W'($urandom_range(0, 45));
      if ($urandom_range(0, 59) == 0) size = SIZE_W'($urandom_range(0, 20));
      if ($urandom_range(0, 59) == 0) rate = RATE_W'($urandom_range(0, 5));
      if ($urandom_range(0, 79) == 0) outneg = !outneg;
      if ($urandom_range(0, 299) == 0) outmode = !outmode;
      if ($urandom_range(0, 5) == 0) ext_trig = !ext_trig;
      tick();
    end
    run = 1'b0;
    outmode = 1'b0;
    ticks(2);

`ifdef EXT_TRIG_EN
    // 6: external trigger edge, then a second edge while the frame is busy
    do_reset();
    set_cfg(1000, 4, 20, 2, 1'b0);
    buf_ready = 1'b1;
    ext_trig  = 1'b0;
    outmode   = 1'b1;
    run       = 1'b1;
    ticks(6);
    clear_tallies();
    begin
      int c0;
      c0 = c;
      for (int i = 0; i < 60; i++) begin
        ext_trig = (i < 5) ? 1'b1 : ((i < 7) ? 1'b0 : 1'b1);
        tick();
      end
      chk("t6_frames", dc_fs, 1);
      chk("t6_latency", last_fs - c0, 3);
      chk("t6_skip", o_skip_cnt, 1);
    end
    run = 1'b0;
    outmode = 1'b0;
    ticks(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
